// File: rtl/pong_aux_core_pkg.sv
// Shared constants and types for the pong game-support primitives.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_aux_core_pkg;

  // Default build constants; the top exposes each as an overridable parameter.
  localparam int              DEF_CLK_FREQ_HZ    = 50_000_000;
  localparam int              DEF_STROBE_FREQ_HZ = 60;
  localparam int              DEF_RND_NUM_W      = 10;
  localparam logic [9:0]      DEF_TAPS           = 10'h240;  // x^10 + x^7 + 1
  localparam int              DEF_COORD_W        = 10;

  // Axis-aligned rectangle: left/top inclusive, right/bottom exclusive.
  typedef struct packed {
    logic [DEF_COORD_W-1:0] left;
    logic [DEF_COORD_W-1:0] right;
    logic [DEF_COORD_W-1:0] top;
    logic [DEF_COORD_W-1:0] bottom;
  } rect_t;

  // Strobe period in clocks; callers guarantee an integer ratio of at least 2.
  function automatic int strobe_period(input int clk_hz, input int strobe_hz);
    return clk_hz / strobe_hz;
  endfunction

endpackage

// File: rtl/pong_aux_core_if.sv
// Bundles the game-support outputs and the two rectangles to compare.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-valued every cycle.
interface pong_aux_core_if
  import pong_aux_core_pkg::*;
#(
  parameter int RND_NUM_W = DEF_RND_NUM_W,
  parameter int COORD_W   = DEF_COORD_W
);
  logic                 strobe_o;
  logic [RND_NUM_W-1:0] rnd_num_o;
  logic [COORD_W-1:0]   rect1_left_i;
  logic [COORD_W-1:0]   rect1_right_i;
  logic [COORD_W-1:0]   rect1_top_i;
  logic [COORD_W-1:0]   rect1_bottom_i;
  logic [COORD_W-1:0]   rect2_left_i;
  logic [COORD_W-1:0]   rect2_right_i;
  logic [COORD_W-1:0]   rect2_top_i;
  logic [COORD_W-1:0]   rect2_bottom_i;
  logic                 collision_o;

  // Game logic side: supplies rectangles, consumes strobe/random/collision.
  modport master (
    output rect1_left_i, rect1_right_i, rect1_top_i, rect1_bottom_i,
    output rect2_left_i, rect2_right_i, rect2_top_i, rect2_bottom_i,
    input  strobe_o, rnd_num_o, collision_o
  );

  // Core side.
  modport slave (
    input  rect1_left_i, rect1_right_i, rect1_top_i, rect1_bottom_i,
    input  rect2_left_i, rect2_right_i, rect2_top_i, rect2_bottom_i,
    output strobe_o, rnd_num_o, collision_o
  );
endinterface

// File: rtl/pong_aux_core_rect_overlap.sv
// Registered overlap test of two half-open axis-aligned rectangles.
// Latency: 1 cycle from inputs to collision_o.
// Backpressure: none; a new comparison is taken every cycle.
module pong_aux_core_rect_overlap
  import pong_aux_core_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [COORD_W-1:0] rect1_left_i,
  input  logic [COORD_W-1:0] rect1_right_i,
  input  logic [COORD_W-1:0] rect1_top_i,
  input  logic [COORD_W-1:0] rect1_bottom_i,
  input  logic [COORD_W-1:0] rect2_left_i,
  input  logic [COORD_W-1:0] rect2_right_i,
  input  logic [COORD_W-1:0] rect2_top_i,
  input  logic [COORD_W-1:0] rect2_bottom_i,
  output logic               collision_o
);

  logic cross_d;
  logic valid_d;
  logic collision_d;
  logic collision_q;

  // Strict compares make edge-touching rectangles miss; the validity term is
  // needed because an inverted rectangle can still satisfy the cross terms.
  always_comb begin
    cross_d = (rect1_left_i < rect2_right_i) && (rect1_right_i > rect2_left_i) &&
              (rect1_top_i < rect2_bottom_i) && (rect1_bottom_i > rect2_top_i);
    valid_d = (rect1_right_i > rect1_left_i) && (rect1_bottom_i > rect1_top_i) &&
              (rect2_right_i > rect2_left_i) && (rect2_bottom_i > rect2_top_i);
    collision_d = cross_d && valid_d;
  end

  // Register the result so the flag is glitch-free for the game logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

endmodule

// File: rtl/pong_aux_core.sv
// Pong support block: periodic strobe, free-running LFSR, rectangle collision.
// Latency: strobe registered, LFSR advances every cycle, collision 1 cycle.
// Backpressure: none; outputs are valid every cycle.
module pong_aux_core
  import pong_aux_core_pkg::*;
#(
  parameter int                   CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int                   STROBE_FREQ_HZ = DEF_STROBE_FREQ_HZ,
  parameter int                   RND_NUM_W      = DEF_RND_NUM_W,
  parameter logic [RND_NUM_W-1:0] TAPS           = RND_NUM_W'(DEF_TAPS),
  parameter int                   COORD_W        = DEF_COORD_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pong_aux_core_if.slave  bus
);

  localparam int                 P      = strobe_period(CLK_FREQ_HZ, STROBE_FREQ_HZ);
  localparam int                 CNT_W  = (P > 1) ? $clog2(P) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(P - 1);
  localparam logic [RND_NUM_W-1:0] SEED = RND_NUM_W'(1);

  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 strobe_q;
  logic                 strobe_d;
  logic [RND_NUM_W-1:0] rnd_q;
  logic [RND_NUM_W-1:0] rnd_d;

  // Next-state for the phase counter, strobe and LFSR.
  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    strobe_d = (cnt_q == CNT_LAST);
    rnd_d    = {rnd_q[RND_NUM_W-2:0], ^(rnd_q & TAPS)};
  end

  // Phase counter wraps at P-1; the strobe lands the cycle after the wrap value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Fibonacci LFSR; the non-zero seed keeps it off the all-zero lock-up state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rnd_q <= SEED;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  pong_aux_core_rect_overlap #(
    .COORD_W (COORD_W)
  ) u_overlap (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rect1_left_i   (bus.rect1_left_i),
    .rect1_right_i  (bus.rect1_right_i),
    .rect1_top_i    (bus.rect1_top_i),
    .rect1_bottom_i (bus.rect1_bottom_i),
    .rect2_left_i   (bus.rect2_left_i),
    .rect2_right_i  (bus.rect2_right_i),
    .rect2_top_i    (bus.rect2_top_i),
    .rect2_bottom_i (bus.rect2_bottom_i),
    .collision_o    (bus.collision_o)
  );

  assign bus.strobe_o  = strobe_q;
  assign bus.rnd_num_o = rnd_q;

endmodule

// File: tb/tb_pong_aux_core.sv
// Self-checking bench for pong_aux_core with a 10-clock strobe period.
// Latency: n/a.
// Backpressure: n/a.
module tb_pong_aux_core;
  import pong_aux_core_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pong_aux_core_if #(.RND_NUM_W(10), .COORD_W(10)) bus ();

  pong_aux_core #(
    .CLK_FREQ_HZ    (100),
    .STROBE_FREQ_HZ (10),
    .RND_NUM_W      (10),
    .TAPS           (10'h240),
    .COORD_W        (10)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    rect_t r1;
    rect_t r2;
    logic  exp;
  } coll_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rect_t r1, input rect_t r2);
    bus.rect1_left_i   = r1.left;
    bus.rect1_right_i  = r1.right;
    bus.rect1_top_i    = r1.top;
    bus.rect1_bottom_i = r1.bottom;
    bus.rect2_left_i   = r2.left;
    bus.rect2_right_i  = r2.right;
    bus.rect2_top_i    = r2.top;
    bus.rect2_bottom_i = r2.bottom;
  endtask

  // Reference LFSR step: double the state modulo 2^10, append tap parity.
  function automatic int lfsr_next(input int s);
    int par;
    par = $countones(s & 'h240) % 2;
    return ((s * 2) % 1024) + par;
  endfunction

  // Reference overlap: the two half-open intervals intersect on both axes.
  function automatic logic overlap(input rect_t a, input rect_t b);
    int lo_x, hi_x, lo_y, hi_y;
    lo_x = (a.left  > b.left)  ? a.left  : b.left;
    hi_x = (a.right < b.right) ? a.right : b.right;
    lo_y = (a.top    > b.top)    ? a.top    : b.top;
    hi_y = (a.bottom < b.bottom) ? a.bottom : b.bottom;
    return (lo_x < hi_x) && (lo_y < hi_y);
  endfunction

  function automatic rect_t mk(input int l, input int r, input int t, input int b);
    rect_t x;
    x.left = 10'(l); x.right = 10'(r); x.top = 10'(t); x.bottom = 10'(b);
    return x;
  endfunction

  initial begin
    coll_vec_t vecs[10];
    int        first_seq[8];
    int        model;
    int        seen_zero;
    rect_t     a, b;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(mk(0, 0, 0, 0), mk(0, 0, 0, 0));

    first_seq = '{1, 2, 4, 8, 16, 32, 64, 129};

    vecs[0] = '{mk(10, 20, 10, 30), mk(15, 25, 25, 35), 1'b1};  // overlap
    vecs[1] = '{mk(10, 20, 10, 30), mk(20, 25, 25, 35), 1'b0};  // touch on x
    vecs[2] = '{mk(10, 20, 10, 30), mk(15, 25, 30, 35), 1'b0};  // touch on y
    vecs[3] = '{mk(10, 20, 10, 30), mk(19, 25, 29, 35), 1'b1};  // one-pixel overlap
    vecs[4] = '{mk(10,  5, 10, 30), mk( 0, 20,  0, 40), 1'b0};  // rect1 inverted
    vecs[5] = '{mk(10, 20, 10, 30), mk(12, 18, 15, 15), 1'b0};  // rect2 zero height
    vecs[6] = '{mk(10, 20, 10, 30), mk(10, 20, 10, 30), 1'b1};  // identical
    vecs[7] = '{mk( 0, 100, 0, 100), mk(40, 41, 40, 41), 1'b1}; // containment
    vecs[8] = '{mk(10, 20, 10, 30), mk( 0,  9, 10, 30), 1'b0};  // disjoint left
    vecs[9] = '{mk(1000, 1023, 900, 1023), mk(1010, 1020, 1000, 1010), 1'b1};

    // Reset values while reset is held.
    #12;
    check("reset_strobe", int'(bus.strobe_o), 0);
    check("reset_rnd", int'(bus.rnd_num_o), 1);
    check("reset_collision", int'(bus.collision_o), 0);

    // Strobe timing and full LFSR period from reset release.
    @(negedge clk);
    rst = 1'b0;
    model = 1;
    seen_zero = 0;
    check("lfsr_k0", int'(bus.rnd_num_o), 1);
    for (int k = 1; k <= 1023; k++) begin
      tick();
      model = lfsr_next(model);
      check($sformatf("strobe_k%0d", k), int'(bus.strobe_o), (k % 10 == 0) ? 1 : 0);
      check($sformatf("lfsr_k%0d", k), int'(bus.rnd_num_o), model);
      if (k < 8) check($sformatf("lfsr_seq%0d", k), int'(bus.rnd_num_o), first_seq[k]);
      if (bus.rnd_num_o == '0) seen_zero++;
    end
    check("lfsr_period_back_to_1", int'(bus.rnd_num_o), 1);
    check("lfsr_zero_count", seen_zero, 0);

    // Directed collision table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].r1, vecs[i].r2);
      tick();
      check($sformatf("coll_vec%0d", i), int'(bus.collision_o), int'(vecs[i].exp));
    end

    // Overlap -> disjoint: flag holds until the next edge, then falls.
    @(negedge clk);
    drive(mk(10, 20, 10, 30), mk(15, 25, 25, 35));
    tick();
    check("fall_pre", int'(bus.collision_o), 1);
    @(negedge clk);
    drive(mk(10, 20, 10, 30), mk(50, 60, 50, 60));
    #1;
    check("fall_hold", int'(bus.collision_o), 1);
    tick();
    check("fall_after", int'(bus.collision_o), 0);

    // Randomised collision against the interval-intersection model.
    for (int i = 0; i < 300; i++) begin
      a = mk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      b = mk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      @(negedge clk);
      drive(a, b);
      tick();
      check($sformatf("coll_rand%0d", i), int'(bus.collision_o), int'(overlap(a, b)));
    end

    // Mid-period asynchronous reset with counter at 5 and collision high.
    @(negedge clk);
    drive(mk(10, 20, 10, 30), mk(15, 25, 25, 35));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      model = lfsr_next(model);
    end
    check("mid_coll_high", int'(bus.collision_o), 1);
    check("mid_lfsr", int'(bus.rnd_num_o), model);
    #2;
    rst = 1'b1;
    #1;
    check("async_strobe", int'(bus.strobe_o), 0);
    check("async_rnd", int'(bus.rnd_num_o), 1);
    check("async_collision", int'(bus.collision_o), 0);
    tick();
    check("held_rnd", int'(bus.rnd_num_o), 1);
    check("held_collision", int'(bus.collision_o), 0);
    @(negedge clk);
    rst = 1'b0;
    model = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      model = lfsr_next(model);
      check($sformatf("restart_strobe_k%0d", k), int'(bus.strobe_o), (k == 10) ? 1 : 0);
      check($sformatf("restart_lfsr_k%0d", k), int'(bus.rnd_num_o), model);
    end
    check("restart_collision", int'(bus.collision_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
